spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Two-requester arbiter and transaction sequencer in front of the single SPI master. Accepts one register access (R/W bit, 7-bit address, 8-bit write data) at a time from either requester, for example the UART command path and the power-up configuration sequencer. The block drives the master's enable and operand inputs and waits for the master's done. It returns read data or a timeout error to the requester that issued the access. Round-robin arbitration keeps either requester from starving the other.

## Interface
- GAP_CYCLES, 4: cycles spi_en is held low between transactions; legal range 1..255.
- TIMEOUT_CYCLES, 4096: maximum BUSY cycles before the transaction is aborted; legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqK_valid  in  1  (K=0,1) request pending; held with its operands until reqK_ready.
- reqK_rw  in  1  1 = read, 0 = write.
- reqK_addr  in  7  register address.
- reqK_wdata  in  8  write data; ignored for reads.
- reqK_ready  out  1  one-cycle pulse: request K accepted.
- rspK_valid  out  1  one-cycle pulse: transaction for K finished.
- rspK_rdata  out  8  read data; valid only with rspK_valid.
- rspK_err  out  1  timeout flag; valid only with rspK_valid.
- spi_en  out  1  enable to the SPI master.
- spi_rw  out  1  R/W bit to the master.
- spi_addr  out  7  address to the master.
- spi_wdata  out  8  write data to the master.
- spi_rdata  in  8  read data from the master.
- spi_done  in  1  master done level; it stays high until the master's next transaction begins.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUSY, GAP.
- IDLE:
  - Grant is decided from reqK_valid and the last-granted pointer `last`.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester that is not `last` wins.
  - On a grant, the block latches rw, addr and wdata into spi_rw, spi_addr and spi_wdata, records owner = K, and sets `last` = K.
  - In the same edge it pulses reqK_ready, sets spi_en=1, clears the timeout counter, and moves to BUSY.
- BUSY:
  - spi_en stays at 1 and the operand outputs stay stable.
  - done_q is spi_done registered; a rise is spi_done & ~done_q.
  - A rise of spi_done completes the transaction. On that edge, if the access was a read, spi_rdata is captured into rsp_rdata; if it was a write, rsp_rdata is 0x00. rsp_err is 0.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no rise, the transaction ends with rsp_err=1 and rsp_rdata=0x00.
  - On either ending, rsp(owner)_valid pulses, spi_en drops to 0, the gap counter is cleared, and the state moves to GAP.
- GAP:
  - spi_en=0 for exactly GAP_CYCLES cycles so the master's bit counter returns to 0.
  - The state then returns to IDLE.
  - No grant is made during GAP.
- A stale high spi_done left over from the previous transaction is never a rise, so it must not complete the new transaction.
- The non-owner's rsp outputs remain 0.
- Requests are never merged or dropped. A valid request that is not granted stays pending until it wins.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (so requester 0 wins the first tie), owner=0, done_q=0.
  - spi_en=0, spi_rw=0, spi_addr=0, spi_wdata=0.
  - reqK_ready=0, rspK_valid=0, rspK_rdata=0, rspK_err=0, busy=0.
- Grant latency: reqK_valid high in IDLE at edge T gives reqK_ready=1 and spi_en=1 during cycle T+1.
- Requester rules:
  - Deassert valid or present a new request after sampling ready.
  - A valid still high during GAP is treated as a new request.
- Completion latency: a spi_done rise sampled at edge D gives rspK_valid during cycle D+1. spi_en=0 from D+1.
- Back-to-back turnaround: the earliest next grant is at edge D+GAP_CYCLES, so spi_en is low for exactly GAP_CYCLES cycles.
- Timeout: the response comes TIMEOUT_CYCLES cycles after the cycle in which spi_en rose.
- Simultaneous timeout expiry and done rise in the same cycle: done wins, and rsp_err=0.
- Reset asserted mid-BUSY or mid-GAP:
  - Next cycle all outputs take their reset values.
  - The in-flight transaction is abandoned and no response is issued.
- Operand changes on reqK_* after the grant have no effect on spi_*.

## Test plan
- Single write: req0 write addr=0x15 wdata=0xA5, model pulses spi_done 1800 cycles later. Expect req0_ready at T+1, spi_addr=0x15, spi_wdata=0xA5, spi_rw=0. Then rsp0_valid with err=0, then GAP_CYCLES low cycles on spi_en.
- Read data return: req1 read addr=0x7F, model drives spi_rdata=0x3C with the done rise. Expect rsp1_valid, rsp1_rdata=0x3C, rsp1_err=0, and rsp0_valid never asserted.
- Round-robin: both requesters valid continuously from reset for 4 transactions. Expect the grant order 0,1,0,1, and each ready pulse exactly one cycle.
- Stale done: hold spi_done high at the grant, fall 10 cycles later, rise 500 cycles later. Expect completion only at the rise.
- Timeout with TIMEOUT_CYCLES=64: the model never asserts done. Expect rsp0_valid with rsp0_err=1 and rdata=0x00 64 cycles after spi_en rises, then a normal GAP.
- Reset mid-BUSY: assert rst for 1 cycle during a transaction. Expect spi_en=0 next cycle, no rsp pulse, and a pending req1 granted first after reset.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// One requester's channel into spi_arbiter: a held request with a ready pulse
// and a single-cycle response.
interface spi_arbiter_if;
  logic       valid;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (output valid, rw, addr, wdata,
                  input  ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  valid, rw, addr, wdata,
                  output ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter and transaction sequencer for two requesters sharing one
// SPI master: grant, wait for a done rise or timeout, respond, then hold a gap.
module spi_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  spi_arbiter_if.slave req0,
  spi_arbiter_if.slave req1,
  output logic         spi_en,
  output logic         spi_rw,
  output logic [6:0]   spi_addr,
  output logic [7:0]   spi_wdata,
  input  logic [7:0]   spi_rdata,
  input  logic         spi_done,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state_q, state_d;
  logic            last_q, owner_q, done_q;
  logic [TW-1:0]   tmo_q;
  logic [GW-1:0]   gap_q;

  logic            rise, tmo_hit, finish, gap_last, grant, grant_id;
  logic [7:0]      rsp_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)  state_d = BUSY;
      BUSY:    if (finish) state_d = GAP;
      GAP: begin
        if (grant)         state_d = BUSY;
        else if (gap_last) state_d = IDLE;
      end
      default:             state_d = IDLE;
    endcase
  end

  // Decoded strobes. The last GAP cycle hands straight over to arbitration so
  // spi_en stays low for exactly GAP_CYCLES cycles between transactions.
  always_comb begin
    busy     = (state_q != IDLE);
    rise     = spi_done & ~done_q;
    tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    finish   = (state_q == BUSY) && (rise || tmo_hit);
    gap_last = (state_q == GAP) && (gap_q == GW'(GAP_CYCLES - 1));
    grant    = ((state_q == IDLE) || gap_last) && (req0.valid || req1.valid);
    grant_id = (req0.valid && req1.valid) ? ~last_q : req1.valid;
    rsp_data = (rise && spi_rw) ? spi_rdata : 8'h00;
  end

  // Operand, pointer, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q         <= 1'b1;
      owner_q        <= 1'b0;
      done_q         <= 1'b0;
      tmo_q          <= '0;
      gap_q          <= '0;
      spi_en         <= 1'b0;
      spi_rw         <= 1'b0;
      spi_addr       <= '0;
      spi_wdata      <= '0;
      req0.ready     <= 1'b0;
      req1.ready     <= 1'b0;
      req0.rsp_valid <= 1'b0;
      req1.rsp_valid <= 1'b0;
      req0.rsp_rdata <= '0;
      req1.rsp_rdata <= '0;
      req0.rsp_err   <= 1'b0;
      req1.rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
      done_q         <= spi_done;
      req0.ready     <= grant && !grant_id;
      req1.ready     <= grant &&  grant_id;
      req0.rsp_valid <= finish && !owner_q;
      req1.rsp_valid <= finish &&  owner_q;
      req0.rsp_rdata <= (finish && !owner_q) ? rsp_data : 8'h00;
      req1.rsp_rdata <= (finish &&  owner_q) ? rsp_data : 8'h00;
      req0.rsp_err   <= finish && !owner_q && !rise;
      req1.rsp_err   <= finish &&  owner_q && !rise;

      if (grant) begin
        owner_q   <= grant_id;
        last_q    <= grant_id;
        spi_en    <= 1'b1;
        tmo_q     <= '0;
        spi_rw    <= grant_id ? req1.rw    : req0.rw;
        spi_addr  <= grant_id ? req1.addr  : req0.addr;
        spi_wdata <= grant_id ? req1.wdata : req0.wdata;
      end else if (finish) begin
        spi_en <= 1'b0;
        gap_q  <= '0;
      end else if (state_q == BUSY) begin
        tmo_q <= tmo_q + 1'b1;
      end else if (state_q == GAP) begin
        gap_q <= gap_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed vectors and corner sequences on
// a long-timeout instance, timeout and randomized traffic on a short-timeout one.
module tb_spi_arbiter;

  localparam int GAP     = 4;
  localparam int TO_MAIN = 4096;
  localparam int TO_T    = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  spi_arbiter_if r0();
  spi_arbiter_if r1();
  logic       spi_en, spi_rw, spi_done, busy;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata, spi_rdata;

  spi_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk(clk), .rst(rst), .req0(r0), .req1(r1),
    .spi_en(spi_en), .spi_rw(spi_rw), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_done(spi_done), .busy(busy)
  );

  // Short-timeout instance
  spi_arbiter_if t0();
  spi_arbiter_if t1();
  logic       t_spi_en, t_spi_rw, t_spi_done, t_busy;
  logic [6:0] t_spi_addr;
  logic [7:0] t_spi_wdata, t_spi_rdata;

  spi_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_T)) dut_to (
    .clk(clk), .rst(rst), .req0(t0), .req1(t1),
    .spi_en(t_spi_en), .spi_rw(t_spi_rw), .spi_addr(t_spi_addr), .spi_wdata(t_spi_wdata),
    .spi_rdata(t_spi_rdata), .spi_done(t_spi_done), .busy(t_busy)
  );

  int checks = 0;
  int failures = 0;
  int mon_rsp0 = 0, mon_rsp1 = 0;
  int exp_rsp0 = 0, exp_rsp1 = 0;

  typedef struct {
    int         k;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] mrd;
    int         hold;
    int         delay;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } req_t;

  vec_t vecs[6];

  always @(negedge clk) begin
    if (r0.rsp_valid === 1'b1) mon_rsp0++;
    if (r1.rsp_valid === 1'b1) mon_rsp1++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic rw,
                         input logic [6:0] a, input logic [7:0] d);
    if (k == 0) begin r0.valid = v; r0.rw = rw; r0.addr = a; r0.wdata = d; end
    else        begin r1.valid = v; r1.rw = rw; r1.addr = a; r1.wdata = d; end
  endtask

  function automatic logic rdy(input int k);
    return (k != 0) ? r1.ready : r0.ready;
  endfunction

  function automatic logic rspv(input int k);
    return (k != 0) ? r1.rsp_valid : r0.rsp_valid;
  endfunction

  function automatic logic [7:0] rspd(input int k);
    return (k != 0) ? r1.rsp_rdata : r0.rsp_rdata;
  endfunction

  function automatic logic rspe(input int k);
    return (k != 0) ? r1.rsp_err : r0.rsp_err;
  endfunction

  // One directed transaction on the main instance. from_gap: the previous
  // transaction's response was seen two cycles ago.
  task automatic run_vec(input vec_t v, input bit from_gap);
    int n;
    set_req(v.k, 1'b1, v.rw, v.addr, v.wdata);
    n = 0;
    while (!rdy(v.k) && n < 50) begin tick(); n++; end
    check("grant_wait", n, from_gap ? GAP - 1 : 1);
    check("grant_other", rdy(1 - v.k), 0);
    check("grant_en", {busy, spi_en}, 2'b11);
    check("grant_ops", {spi_rw, spi_addr, spi_wdata}, {v.rw, v.addr, v.wdata});
    if (v.hold == 0) spi_done = 1'b0;
    set_req(v.k, 1'b0, ~v.rw, ~v.addr, ~v.wdata);
    tick();
    check("ready_pulse", rdy(v.k), 0);
    check("ops_stable", {spi_rw, spi_addr, spi_wdata}, {v.rw, v.addr, v.wdata});
    if (v.hold > 0) begin
      repeat (v.hold - 1) tick();
      spi_done = 1'b0;
      check("stale_ignored", {spi_en, rspv(v.k)}, 2'b10);
    end
    repeat (v.delay) tick();
    check("pre_done_en", spi_en, 1);
    spi_rdata = v.mrd;
    spi_done  = 1'b1;
    tick();
    check("rsp_valid", rspv(v.k), 1);
    check("rsp_rdata", rspd(v.k), v.exp_rdata);
    check("rsp_err", rspe(v.k), v.exp_err);
    check("rsp_other", rspv(1 - v.k), 0);
    check("rsp_en_off", spi_en, 0);
    if (v.k == 0) exp_rsp0++; else exp_rsp1++;
    tick();
    check("rsp_pulse", {rspv(v.k), spi_en}, 0);
  endtask

  task automatic round_robin();
    int n;
    int w;
    int last_m;
    rst = 1'b1;
    spi_done = 1'b0;
    set_req(0, 1'b1, 1'b0, 7'h01, 8'h11);
    set_req(1, 1'b1, 1'b1, 7'h02, 8'h22);
    tick();
    tick();
    check("rr_no_grant_in_rst", {r1.ready, r0.ready}, 0);
    rst = 1'b0;
    last_m = 1;
    for (int j = 0; j < 4; j++) begin
      w = 1 - last_m;
      last_m = w;
      n = 0;
      while (!(r0.ready || r1.ready) && n < 20) begin tick(); n++; end
      check("rr_grant", {r1.ready, r0.ready}, (w != 0) ? 2 : 1);
      check("rr_addr", spi_addr, (w != 0) ? 2 : 1);
      tick();
      check("rr_ready_width", {r1.ready, r0.ready}, 0);
      repeat (4) tick();
      spi_rdata = 8'(8'h40 + j);
      spi_done  = 1'b1;
      tick();
      check("rr_rsp", {r1.rsp_valid, r0.rsp_valid}, (w != 0) ? 2 : 1);
      check("rr_rdata", (w != 0) ? r1.rsp_rdata : r0.rsp_rdata,
            (w != 0) ? 8'(8'h40 + j) : 8'h00);
      if (w != 0) exp_rsp1++; else exp_rsp0++;
      spi_done = 1'b0;
      if (j == 3) begin
        set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
      end
    end
    repeat (GAP + 2) tick();
    check("rr_idle", {busy, spi_en}, 0);
  endtask

  task automatic timeout_seq();
    int n;
    t_spi_done  = 1'b0;
    t_spi_rdata = 8'h5A;
    t0.valid = 1'b1; t0.rw = 1'b1; t0.addr = 7'h11; t0.wdata = 8'h00;
    tick();
    check("to_grant", {t0.ready, t_spi_en}, 2'b11);
    t0.valid = 1'b0;
    n = 0;
    while (!t0.rsp_valid && n < 200) begin tick(); n++; end
    check("to_latency", n, TO_T);
    check("to_err", t0.rsp_err, 1);
    check("to_rdata", t0.rsp_rdata, 8'h00);
    check("to_other", t1.rsp_valid, 0);
    check("to_en_off", t_spi_en, 0);
    t1.valid = 1'b1; t1.rw = 1'b1; t1.addr = 7'h22; t1.wdata = 8'h00;
    n = 0;
    while (!t1.ready && n < 50) begin tick(); n++; end
    check("to_gap", n, GAP);
    t1.valid = 1'b0;
    repeat (TO_T - 1) tick();
    t_spi_rdata = 8'h96;
    t_spi_done  = 1'b1;
    tick();
    check("tie_valid", t1.rsp_valid, 1);
    check("tie_err", t1.rsp_err, 0);
    check("tie_rdata", t1.rsp_rdata, 8'h96);
  endtask

  // Transaction-level model: pending requests per requester, a last-winner
  // pointer, and a response latency of min(done delay + 1, timeout).
  task automatic random_seq();
    req_t pend[2];
    req_t cur;
    int   w, n, d, tlast, exp_n;
    logic [7:0] mrd;
    logic exp_err;
    pend[0] = '0;
    pend[1] = '0;
    tlast = 1;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k].v && $urandom_range(0, 3) != 0) begin
          pend[k].v     = 1'b1;
          pend[k].rw    = 1'($urandom_range(0, 1));
          pend[k].addr  = 7'($urandom_range(0, 127));
          pend[k].wdata = 8'($urandom_range(0, 255));
        end
      end
      if (!pend[0].v && !pend[1].v) begin
        pend[0].v = 1'b1; pend[0].rw = 1'b1;
        pend[0].addr = 7'($urandom_range(0, 127)); pend[0].wdata = 8'h00;
      end
      t0.valid = pend[0].v; t0.rw = pend[0].rw; t0.addr = pend[0].addr; t0.wdata = pend[0].wdata;
      t1.valid = pend[1].v; t1.rw = pend[1].rw; t1.addr = pend[1].addr; t1.wdata = pend[1].wdata;
      w = (pend[0].v && pend[1].v) ? 1 - tlast : (pend[1].v ? 1 : 0);
      n = 0;
      while (!(t0.ready || t1.ready) && n < 50) begin tick(); n++; end
      cur = pend[w];
      check("rnd_grant", {t1.ready, t0.ready}, (w != 0) ? 2 : 1);
      check("rnd_ops", {t_spi_rw, t_spi_addr, t_spi_wdata}, {cur.rw, cur.addr, cur.wdata});
      tlast = w;
      pend[w].v = 1'b0;
      if (w != 0) t1.valid = 1'b0; else t0.valid = 1'b0;
      t_spi_done = 1'b0;
      d   = $urandom_range(1, 90);
      mrd = 8'($urandom_range(0, 255));
      t_spi_rdata = mrd;
      exp_n   = (d + 1 <= TO_T) ? d + 1 : TO_T;
      exp_err = (d + 1 > TO_T);
      n = 0;
      while (!(t0.rsp_valid || t1.rsp_valid) && n < 200) begin
        if (n == d) t_spi_done = 1'b1;
        tick();
        n++;
      end
      check("rnd_latency", n, exp_n);
      check("rnd_owner", {t1.rsp_valid, t0.rsp_valid}, (w != 0) ? 2 : 1);
      check("rnd_err", (w != 0) ? t1.rsp_err : t0.rsp_err, exp_err);
      check("rnd_rdata", (w != 0) ? t1.rsp_rdata : t0.rsp_rdata,
            (!exp_err && cur.rw) ? mrd : 8'h00);
    end
    t0.valid = 1'b0;
    t1.valid = 1'b0;
  endtask

  task automatic reset_mid_busy();
    set_req(0, 1'b1, 1'b1, 7'h0A, 8'h5C);
    tick();
    check("rmb_grant0", r0.ready, 1);
    set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_req(1, 1'b1, 1'b1, 7'h0B, 8'h00);
    repeat (5) tick();
    check("rmb_busy", {busy, spi_en}, 2'b11);
    rst = 1'b1;
    tick();
    check("rmb_en", {busy, spi_en}, 0);
    check("rmb_ops", {spi_rw, spi_addr, spi_wdata}, 0);
    check("rmb_ready", {r1.ready, r0.ready}, 0);
    check("rmb_rsp", {r1.rsp_valid, r0.rsp_valid}, 0);
    rst = 1'b0;
    tick();
    check("rmb_first", {r1.ready, r0.ready}, 2'b10);
    check("rmb_addr", spi_addr, 7'h0B);
    set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
    repeat (3) tick();
    spi_rdata = 8'hE1;
    spi_done  = 1'b1;
    tick();
    check("rmb_rsp1", {r1.rsp_valid, r1.rsp_err, r1.rsp_rdata}, {1'b1, 1'b0, 8'hE1});
    exp_rsp1++;
    spi_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 7'h15, 8'hA5, 8'h00, 0, 1800, 8'h00, 1'b0};
    vecs[1] = '{1, 1'b1, 7'h7F, 8'h00, 8'h3C, 0,   20, 8'h3C, 1'b0};
    vecs[2] = '{0, 1'b1, 7'h00, 8'hFF, 8'hFF, 0,    0, 8'hFF, 1'b0};
    vecs[3] = '{1, 1'b0, 7'h2A, 8'h00, 8'h77, 0,    3, 8'h00, 1'b0};
    vecs[4] = '{0, 1'b1, 7'h55, 8'h12, 8'h81, 0,    7, 8'h81, 1'b0};
    vecs[5] = '{1, 1'b1, 7'h33, 8'h44, 8'hC3, 10, 490, 8'hC3, 1'b0};

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
    t0.valid = 1'b0; t0.rw = 1'b0; t0.addr = 7'h00; t0.wdata = 8'h00;
    t1.valid = 1'b0; t1.rw = 1'b0; t1.addr = 7'h00; t1.wdata = 8'h00;
    spi_done = 1'b0;  spi_rdata = 8'h00;
    t_spi_done = 1'b0; t_spi_rdata = 8'h00;
    tick();
    tick();

    check("rst_spi_en", spi_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ops", {spi_rw, spi_addr, spi_wdata}, 0);
    check("rst_ready", {r1.ready, r0.ready}, 0);
    check("rst_rsp_valid", {r1.rsp_valid, r0.rsp_valid}, 0);
    check("rst_rsp_data", {r1.rsp_rdata, r0.rsp_rdata, r1.rsp_err, r0.rsp_err}, 0);
    check("rst_t_en_busy", {t_busy, t_spi_en}, 0);

    rst = 1'b0;
    tick();
    check("idle_busy", {busy, spi_en}, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i > 0);
    round_robin();
    timeout_seq();
    random_seq();
    reset_mid_busy();

    repeat (2) tick();
    check("mon_rsp0_count", mon_rsp0, exp_rsp0);
    check("mon_rsp1_count", mon_rsp1, exp_rsp1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
